// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants, receiver state encoding and parameter legality check.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    function automatic bit rx_params_legal(input int clks_per_bit, input int data_bits,
                                           input int parity, input int stop_bits);
        return (clks_per_bit >= 4) && (clks_per_bit <= 65535) &&
               (data_bits >= 5) && (data_bits <= 9) &&
               (parity >= PAR_NONE) && (parity <= PAR_ODD) &&
               ((stop_bits == 1) || (stop_bits == 2));
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - two-flop synchronizer with falling-edge detect.
module uart_rx_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic fall
);

    logic meta;
    logic sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RESET_VAL;
            sync <= RESET_VAL;
        end else begin
            meta <= d;
            sync <= meta;
        end
    end

    assign q = sync;
    // Flags the 1->0 transition one cycle before it appears on q so the
    // half-bit count centres the start bit at N+2+CLKS_PER_BIT/2.
    assign fall = sync & ~meta;

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - parametrised oversampling UART receiver with valid/ready output and error flags.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 serial_in,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int                CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_BIT  = CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [CNT_W-1:0] RELOAD    = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]       LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]       LAST_STOP = 4'(STOP_BITS - 1);

    if (!rx_params_legal(CLKS_PER_BIT, DATA_BITS, PARITY, STOP_BITS)) begin : g_param_check
        $error("uart_rx: illegal parameter combination");
    end

    logic                 line;
    logic                 fall;
    rx_state_t            state;
    rx_state_t            state_nx;
    logic [CNT_W-1:0]     cnt;
    logic                 tick;
    logic [3:0]           bit_cnt;
    logic [DATA_BITS-1:0] shift;
    logic                 par_bad;
    logic                 stop_bad;
    logic                 last_stop;
    logic                 done_q;
    logic [DATA_BITS-1:0] fin_data;
    logic                 fin_perr;
    logic                 fin_ferr;

    uart_rx_sync #(
        .RESET_VAL(1'b1)
    ) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (serial_in),
        .q    (line),
        .fall (fall)
    );

    assign tick = (cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RX_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        busy      = (state != RX_IDLE);
        last_stop = 1'b0;
        case (state)
            RX_IDLE: begin
                if (fall) state_nx = RX_START;
            end
            RX_START: begin
                // A line back at 1 by mid start bit was a glitch.
                if (tick) state_nx = line ? RX_IDLE : RX_DATA;
            end
            RX_DATA: begin
                if (tick && (bit_cnt == LAST_DATA))
                    state_nx = (PARITY != PAR_NONE) ? RX_PARITY : RX_STOP;
            end
            RX_PARITY: begin
                if (tick) state_nx = RX_STOP;
            end
            RX_STOP: begin
                if (tick && (bit_cnt == LAST_STOP)) begin
                    last_stop = 1'b1;
                    state_nx  = RX_IDLE;
                end
            end
            default: state_nx = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= HALF_BIT;
            bit_cnt  <= '0;
            shift    <= '0;
            par_bad  <= 1'b0;
            stop_bad <= 1'b0;
            done_q   <= 1'b0;
            fin_data <= '0;
            fin_perr <= 1'b0;
            fin_ferr <= 1'b0;
        end else begin
            if (state == RX_IDLE) begin
                cnt <= HALF_BIT;
            end else if (tick) begin
                cnt <= RELOAD;
            end else begin
                cnt <= cnt - 1'b1;
            end

            if (state_nx != state) begin
                bit_cnt <= '0;
            end else if (tick) begin
                bit_cnt <= bit_cnt + 4'd1;
            end

            if ((state == RX_DATA) && tick) begin
                shift <= {line, shift[DATA_BITS-1:1]};
            end

            if (state == RX_IDLE) begin
                par_bad  <= 1'b0;
                stop_bad <= 1'b0;
            end
            if ((state == RX_PARITY) && tick) begin
                par_bad <= (PARITY == PAR_ODD) ? ~(^shift ^ line) : (^shift ^ line);
            end
            if ((state == RX_STOP) && tick && !line) begin
                stop_bad <= 1'b1;
            end

            done_q <= last_stop;
            if (last_stop) begin
                fin_data <= shift;
                fin_perr <= par_bad;
                fin_ferr <= stop_bad | ~line;
            end
        end
    end

    // Output holding register: a completion only loads when the slot is free
    // or being drained on the same edge; otherwise the new character is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (done_q) begin
                if (!rx_valid || rx_ready) begin
                    rx_data    <= fin_data;
                    parity_err <= fin_perr;
                    frame_err  <= fin_ferr;
                    rx_valid   <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Parametrised UART receive engine and successor to the fixed 8-bit receiver. It oversamples an asynchronous serial line, frames start/data/parity/stop bits with configurable widths and parity mode, and delivers each character over a valid/ready handshake with per-character error flags. It sits between the chip-level RX pad and the UART register/FIFO layer.

## Interface
- CLKS_PER_BIT, 16, clk cycles per bit period; legal range 4..65535.
- DATA_BITS, 8, data bits per character; legal range 5..9.
- PARITY, 0, parity mode: 0 none, 1 even, 2 odd.
- STOP_BITS, 1, stop bits checked; 1 or 2.
- clk  in  1  single clock. All logic is on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- serial_in  in  1  asynchronous RX line. Idle is 1, start bit is 0, data is sent LSB first.
- rx_data  out  DATA_BITS  received character. Stable while rx_valid is high.
- rx_valid  out  1  character available.
- rx_ready  in  1  consumer accepts the character.
- parity_err  out  1  parity mismatch on the held character. Meaningful only while rx_valid is high; always 0 when PARITY=0.
- frame_err  out  1  at least one stop bit sampled 0 on the held character. Meaningful only while rx_valid is high.
- overrun  out  1  one-cycle pulse: a completed character was dropped.
- busy  out  1  FSM is not in IDLE.

## Operation
- Input path: 2-flop synchronizer on serial_in. Both flops reset to 1.
- Start detection uses only a 1→0 transition of the synchronized line. A line held low, such as a break, yields at most one frame.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE→START on a falling edge. The bit counter loads CLKS_PER_BIT/2 (integer division).
  - START: at the half-bit point, if the line is 1, treat it as a glitch and return to IDLE with no output. If the line is 0, go to DATA.
  - DATA: sample every CLKS_PER_BIT cycles. Shift LSB-first into a DATA_BITS shift register. After DATA_BITS samples, go to PARITY if PARITY≠0, otherwise go to STOP.
  - PARITY: sample once. For even parity, error if XOR(data,sample)=1. For odd parity, error if XOR(data,sample)=0.
  - STOP: sample STOP_BITS times. Any 0 sets the frame error, but all STOP_BITS are still sampled. After the last stop sample, go to IDLE in the same cycle. A start edge is then accepted on the next cycle.
- Completion:
  - On the last stop sample, load rx_data, parity_err and frame_err, and set rx_valid on the following edge.
  - Characters with errors are delivered, not discarded.
- Handshake:
  - rx_valid stays high until an edge where rx_valid && rx_ready is true.
  - rx_data and the error flags do not change while rx_valid is high.
- Overrun:
  - If a character completes while rx_valid is high and rx_ready is low, the new character is dropped and the held character is kept.
  - overrun pulses for 1 cycle.
- Simultaneous events:
  - Completion in the same cycle as an accepting handshake: no overrun. The new character loads and rx_valid stays high.
  - Acceptance without a completion: rx_valid goes to 0 on the next edge.
- Counter: $clog2(CLKS_PER_BIT) bits; it reloads CLKS_PER_BIT-1 on each sample point.

## Timing
- Reset values: rx_data=0, rx_valid=0, parity_err=0, frame_err=0, overrun=0, busy=0. The FSM resets to IDLE and the synchronizer flops to 1.
- Reset mid-frame aborts immediately. The partial character is lost and no overrun is raised.
- Latency: let N be the first edge that registers serial_in=0. rx_valid rises at edge N + 2 + CLKS_PER_BIT/2 + (DATA_BITS + (PARITY≠0) + STOP_BITS)·CLKS_PER_BIT + 1.
- Sample point k (k=0 is the start bit) is at N + 2 + CLKS_PER_BIT/2 + k·CLKS_PER_BIT.
- Tolerance: the receiver meets ±3% baud mismatch for CLKS_PER_BIT≥16.
- busy is high from the START entry edge until the IDLE return edge.

## Structure
- Shared package uart_pkg:
  - parity mode constants PAR_NONE, PAR_EVEN and PAR_ODD;
  - rx state enum (IDLE, START, DATA, PARITY, STOP);
  - an elaboration-time parameter legality check.
- Sub-module: uart_rx_sync, a 2-flop synchronizer with reset value parameter and falling-edge detect output.
- The baud counter, shift register and FSM are inline in uart_rx.

## Test plan
- 8N1, CLKS_PER_BIT=16, byte 0xA5, rx_ready held 1 → rx_valid high at N+155 for exactly 1 cycle, rx_data=0xA5, parity_err=0, frame_err=0.
- 7E2, byte 0x41 sent with parity bit 1 (wrong; even parity requires 0) → rx_data=0x41 delivered with parity_err=1, frame_err=0; the repeated frame with parity bit 0 gives parity_err=0.
- 8N1, byte 0x3C with stop bit 0, then the line held low for 40 bit times → exactly one character, 0x3C with frame_err=1. There is no further rx_valid until the line returns high and a new start edge arrives.
- Glitch rejection: serial_in low for 3 cycles, CLKS_PER_BIT=16 → busy pulses, no rx_valid, FSM back in IDLE before the next bit period.
- Backpressure, rx_ready=0, bytes 0x11 then 0x22 back to back:
  - rx_data stays 0x11 and overrun pulses once when 0x22 completes.
  - Repeat with rx_ready asserted exactly on the 0x22 completion cycle → no overrun, and rx_data=0x22 next cycle.
- Reset: rst_n low during the 4th data bit of 0xFF → all outputs 0 asynchronously. A clean 0x5A after release is received correctly.
